// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the RV32I datapath.
// master = control FSM, slave = datapath / memory side.
interface multicycle_control_fsm_if;
   logic [6:0] op;
   logic       Zero;
   logic       mem_ready;
   logic       AdrSrc;
   logic       IRWrite;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] ResultSrc;
   logic [1:0] ImmSrc;
   logic       PCWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic       illegal_instr;
   logic [3:0] state;

   modport master (
      input  op, Zero, mem_ready,
      output AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc,
             PCWrite, RegWrite, MemWrite, illegal_instr, state
   );

   modport slave (
      output op, Zero, mem_ready,
      input  AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc,
             PCWrite, RegWrite, MemWrite, illegal_instr, state
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I datapath.
// Mux selects are registered alongside the state (decoded from the next
// state); the write strobes that depend on mem_ready/Zero/op are formed
// combinationally from the current state and gated off while reset is high.
module multicycle_control_fsm (
   input  logic                       clk,
   input  logic                       reset,
   multicycle_control_fsm_if.master   bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   typedef struct packed {
      logic       adrsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] resultsrc;
      logic       regwrite;
   } moore_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   state_t st, nxt;
   moore_t mo;
   logic   op_ok;

   // Moore select values for a given state; anything not listed stays 0.
   function automatic moore_t moore_of(input state_t s);
      moore_t m;
      m = '0;
      case (s)
         S_FETCH:    begin m.alusrcb = 2'b10; m.resultsrc = 2'b10; end
         S_DECODE:   begin m.alusrca = 2'b01; m.alusrcb = 2'b01; end
         S_MEMADR:   begin m.alusrca = 2'b10; m.alusrcb = 2'b01; end
         S_MEMREAD:  m.adrsrc = 1'b1;
         S_MEMWB:    begin m.resultsrc = 2'b01; m.regwrite = 1'b1; end
         S_MEMWRITE: m.adrsrc = 1'b1;
         S_EXECR:    begin m.alusrca = 2'b10; m.aluop = 2'b10; end
         S_EXECI:    begin m.alusrca = 2'b10; m.alusrcb = 2'b01; m.aluop = 2'b10; end
         S_ALUWB:    m.regwrite = 1'b1;
         S_BEQ:      begin m.alusrca = 2'b10; m.aluop = 2'b01; end
         S_JAL:      begin m.alusrca = 2'b01; m.alusrcb = 2'b10; end
         default:    m = '0;
      endcase
      return m;
   endfunction

   // Opcode legality check used to flag unsupported instructions in DECODE.
   always_comb begin
      op_ok = 1'b0;
      case (bus.op)
         OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_ok = 1'b1;
         default:                                  op_ok = 1'b0;
      endcase
   end

   // Next-state logic; memory states hold until mem_ready.
   always_comb begin
      nxt = st;
      case (st)
         S_FETCH:    if (bus.mem_ready) nxt = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_R:         nxt = S_EXECR;
               OP_I:         nxt = S_EXECI;
               OP_BEQ:       nxt = S_BEQ;
               OP_JAL:       nxt = S_JAL;
               default:      nxt = S_FETCH;
            endcase
         end
         S_MEMADR:   nxt = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (bus.mem_ready) nxt = S_MEMWB;
         S_MEMWB:    nxt = S_FETCH;
         S_MEMWRITE: if (bus.mem_ready) nxt = S_FETCH;
         S_EXECR:    nxt = S_ALUWB;
         S_EXECI:    nxt = S_ALUWB;
         S_ALUWB:    nxt = S_FETCH;
         S_BEQ:      nxt = S_FETCH;
         S_JAL:      nxt = S_ALUWB;
         default:    nxt = S_FETCH;
      endcase
   end

   // State register plus registered Moore selects decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         st <= S_FETCH;
         mo <= moore_of(S_FETCH);
      end else begin
         st <= nxt;
         mo <= moore_of(nxt);
      end
   end

   // Immediate format follows the opcode regardless of state.
   always_comb begin
      bus.ImmSrc = 2'b00;
      case (bus.op)
         OP_SW:   bus.ImmSrc = 2'b01;
         OP_BEQ:  bus.ImmSrc = 2'b10;
         OP_JAL:  bus.ImmSrc = 2'b11;
         default: bus.ImmSrc = 2'b00;
      endcase
   end

   assign bus.state     = st;
   assign bus.AdrSrc    = mo.adrsrc;
   assign bus.ALUSrcA   = mo.alusrca;
   assign bus.ALUSrcB   = mo.alusrcb;
   assign bus.ALUOp     = mo.aluop;
   assign bus.ResultSrc = mo.resultsrc;

   // Write strobes are suppressed for the whole reset cycle, even mid-instruction.
   assign bus.IRWrite       = ~reset & (st == S_FETCH) & bus.mem_ready;
   assign bus.PCWrite       = ~reset & (((st == S_FETCH) & bus.mem_ready) |
                                        ((st == S_BEQ) & bus.Zero) |
                                        (st == S_JAL));
   assign bus.RegWrite      = ~reset & mo.regwrite;
   assign bus.MemWrite      = ~reset & (st == S_MEMWRITE);
   assign bus.illegal_instr = ~reset & (st == S_DECODE) & ~op_ok;

endmodule
